// File: rtl/cell_mem_pkg.sv
// Shared definitions for the cell position RAM controllers: FSM encoding and RAM timing constants.
package cell_mem_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CNT_RD   = 3'd1,
        CNT_WAIT = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4
    } cell_state_e;

    localparam int RAM_RD_LATENCY = 2;
    localparam int COUNT_ADDR     = 0;
    localparam int POS_COMP_WIDTH = 32;

endpackage

// File: rtl/cell_rd_tag_pipe.sv
// Carries {valid, pid, last} tags alongside an issued RAM read so they emerge in the cycle ram_q holds
// the matching word.
module cell_rd_tag_pipe
    import cell_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = RAM_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_pid,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last
);

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      last_q;
    logic [ADDR_WIDTH-1:0] pid_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < DEPTH; i++) pid_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            last_q[0]  <= in_last;
            pid_q[0]   <= in_pid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
                pid_q[i]   <= pid_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_pid   = pid_q[DEPTH-1];
    assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/cell_pos_access_ctrl.sv
// Sequences one single-port cell position RAM: streams a whole cell on rd_start and arbitrates writes.
// Define CELL_CTRL_WR_INTERLEAVE_EN to also grant writes between stream reads.
module cell_pos_access_ctrl
    import cell_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 3 * POS_COMP_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_pid,
    output logic                  rd_done,
    output logic                  cnt_err,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT  = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(COUNT_ADDR);

    cell_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wait_q, wait_d, drain_q, drain_d;
    logic                  tag_v_q, tag_v_d, tag_last_q, tag_last_d;
    logic                  done_zero_q, done_zero_d, busy_q, err_q, err_d;
    logic                  rden_q, rden_d, wren_q, wren_d, ack_q, ack_d;
    logic [ADDR_WIDTH-1:0] raw_cnt, clamp_cnt, next_addr;
    logic                  over_cnt, wr_ok;
    logic                  pipe_valid, pipe_last;
    logic [ADDR_WIDTH-1:0] pipe_pid;

    assign raw_cnt   = ram_q[ADDR_WIDTH-1:0];
    assign over_cnt  = raw_cnt > MAX_CNT;
    assign clamp_cnt = over_cnt ? MAX_CNT : raw_cnt;
    assign next_addr = rd_addr_q + 1'b1;
    // A request still high during its own ack cycle is the one just served, not a new one.
    assign wr_ok     = wr_req & ~ack_q;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        count_d     = count_q;
        wait_d      = wait_q;
        drain_d     = drain_q;
        err_d       = err_q;
        addr_d      = '0;
        data_d      = '0;
        rden_d      = 1'b0;
        wren_d      = 1'b0;
        ack_d       = 1'b0;
        tag_v_d     = 1'b0;
        tag_last_d  = 1'b0;
        done_zero_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    state_d = CNT_RD;
                    addr_d  = CNT_ADDR;
                    rden_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (wr_ok) begin
                    wren_d = 1'b1;
                    ack_d  = 1'b1;
                    addr_d = wr_addr;
                    data_d = wr_data;
                end
            end
            CNT_RD: begin
                state_d = CNT_WAIT;
                wait_d  = 1'b0;
            end
            CNT_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    // ram_q holds the count word during this cycle.
                    count_d = clamp_cnt;
                    err_d   = over_cnt;
                    if (clamp_cnt == '0) begin
                        state_d     = DRAIN;
                        drain_d     = 1'b0;
                        done_zero_d = 1'b1;
                    end else begin
                        state_d    = STREAM;
                        addr_d     = ADDR_WIDTH'(1);
                        rden_d     = 1'b1;
                        tag_v_d    = 1'b1;
                        tag_last_d = (clamp_cnt == ADDR_WIDTH'(1));
                        rd_addr_d  = ADDR_WIDTH'(1);
                    end
                end
            end
            STREAM: begin
                if (rd_addr_q == count_q) begin
                    state_d = DRAIN;
                    drain_d = 1'b1;
`ifdef CELL_CTRL_WR_INTERLEAVE_EN
                end else if (wr_ok) begin
                    wren_d = 1'b1;
                    ack_d  = 1'b1;
                    addr_d = wr_addr;
                    data_d = wr_data;
`endif
                end else begin
                    addr_d     = next_addr;
                    rden_d     = 1'b1;
                    tag_v_d    = 1'b1;
                    tag_last_d = (next_addr == count_q);
                    rd_addr_d  = next_addr;
                end
            end
            DRAIN: begin
                if (!drain_q) state_d = IDLE;
                else          drain_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            count_q     <= '0;
            wait_q      <= 1'b0;
            drain_q     <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            ack_q       <= 1'b0;
            tag_v_q     <= 1'b0;
            tag_last_q  <= 1'b0;
            done_zero_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            drain_q     <= drain_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
            ack_q       <= ack_d;
            tag_v_q     <= tag_v_d;
            tag_last_q  <= tag_last_d;
            done_zero_q <= done_zero_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    cell_rd_tag_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (RAM_RD_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (tag_v_q),
        .in_pid    (addr_q),
        .in_last   (tag_last_q),
        .out_valid (pipe_valid),
        .out_pid   (pipe_pid),
        .out_last  (pipe_last)
    );

    assign ram_address = addr_q;
    assign ram_data    = data_q;
    assign ram_rden    = rden_q;
    assign ram_wren    = wren_q;
    assign wr_ack      = ack_q;
    assign rd_busy     = busy_q;
    assign cnt_err     = err_q;
    assign rd_valid    = pipe_valid;
    assign rd_pid      = pipe_pid;
    assign rd_done     = (pipe_valid & pipe_last) | done_zero_q;
    // The RAM output register already aligns ram_q with the tag; gate it so idle cycles read as zero.
    assign rd_data     = pipe_valid ? ram_q : '0;

endmodule

// File: tb/tb_cell_pos_access_ctrl.sv
// Directed bench for cell_pos_access_ctrl with a 2-cycle single-port RAM model and a read scoreboard.
module tb_cell_pos_access_ctrl;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_start, rd_busy, rd_valid, rd_done, cnt_err;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_pid;
    logic          wr_req, wr_ack;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_rden, ram_wren;

    always #5 clk = ~clk;

    cell_pos_access_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rd_start(rd_start), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_pid(rd_pid), .rd_done(rd_done), .cnt_err(cnt_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_address(ram_address), .ram_data(ram_data), .ram_rden(ram_rden),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    function automatic logic [DW-1:0] pos_word(input int k);
        return {32'(k * 7 + 256), 32'hC0DE_0000 | 32'(k), 32'h5A00_0000 + 32'(k)};
    endfunction

    // RAM model: address in cycle c, data on ram_q in cycle c+2
    logic          ram_init;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ram_stage;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? '0 : pos_word(i);
            ram_stage <= '0;
            ram_q     <= '0;
        end else begin
            if (ram_wren) mem[ram_address] <= ram_data;
            ram_stage <= ram_rden ? mem[ram_address] : '0;
            ram_q     <= ram_stage;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0;
    logic [AW+DW-1:0] exp_q [$];
    int base = 0;
    int valid_cnt, done_cnt, first_rel, last_rel, done_rel, busy_low_rel, ack_rel;
    logic [AW-1:0] last_pid;
    logic both_hi = 1'b0, ack_mis = 1'b0;
    logic [DW-1:0] aval;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    initial begin
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (ram_rden && ram_wren) both_hi = 1'b1;
            if (wr_ack !== ram_wren) ack_mis = 1'b1;
            if (rd_valid) begin
                valid_cnt++;
                if (first_rel < 0) first_rel = cyc - base;
                last_rel = cyc - base;
                last_pid = rd_pid;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", 128'(rd_pid), 128'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pid", 128'(rd_pid), 128'(e[AW+DW-1:DW]));
                    check("sb_data", 128'(rd_data), 128'(e[DW-1:0]));
                end
            end
            if (rd_done) begin
                done_cnt++;
                done_rel = cyc - base;
            end
            if (wr_ack) ack_rel = cyc - base;
            if (!rd_busy && busy_low_rel < 0 && done_cnt > 0) busy_low_rel = cyc - base;
        end
    end

    task automatic clear_mon();
        valid_cnt = 0; done_cnt = 0; first_rel = -1; last_rel = -1;
        done_rel = -1; busy_low_rel = -1; ack_rel = -1; last_pid = '0;
    endtask

    task automatic push_stream(input int n);
        for (int k = 1; k <= n; k++) exp_q.push_back({AW'(k), pos_word(k)});
    endtask

    // Cycle 1 is the cycle right after the edge that samples rd_start.
    task automatic start_read();
        @(negedge clk);
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        base = cyc - 1;
        rd_start = 1'b0;
    endtask

    task automatic wait_stream(input string tag);
        int k;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done_cnt > 0 && !rd_busy) break;
        end
        check(tag, 128'(k < 600), 128'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        @(negedge clk);
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (wr_ack) break;
        end
        wr_req = 1'b0;
        check("wr_ack_seen", 128'(k < 600), 128'd1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst = 1'b1; ram_init = 1'b1; rd_start = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        aval = {24{4'hA}};
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 128'(rd_busy), 0);
        check("rst_valid", 128'(rd_valid), 0);
        check("rst_done", 128'(rd_done), 0);
        check("rst_err", 128'(cnt_err), 0);
        check("rst_ack", 128'(wr_ack), 0);
        check("rst_rden", 128'(ram_rden), 0);
        check("rst_wren", 128'(ram_wren), 0);
        check("rst_addr", 128'(ram_address), 0);
        ram_init = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: three particles
        do_write(8'd0, DW'(3));
        clear_mon(); push_stream(3);
        start_read();
        check("t1_cnt_addr", 128'(ram_address), 0);
        check("t1_cnt_rden", 128'(ram_rden), 1);
        check("t1_busy_rise", 128'(rd_busy), 1);
        wait_stream("t1_timeout");
        check("t1_first_valid", 128'(first_rel), 6);
        check("t1_last_valid", 128'(last_rel), 8);
        check("t1_valid_cnt", 128'(valid_cnt), 3);
        check("t1_last_pid", 128'(last_pid), 3);
        check("t1_done_cyc", 128'(done_rel), 8);
        check("t1_done_cnt", 128'(done_cnt), 1);
        check("t1_busy_low", 128'(busy_low_rel), 9);

        // T2: empty cell
        do_write(8'd0, DW'(0));
        clear_mon();
        start_read();
        wait_stream("t2_timeout");
        check("t2_valid_cnt", 128'(valid_cnt), 0);
        check("t2_done_cyc", 128'(done_rel), 4);
        check("t2_busy_low", 128'(busy_low_rel), 5);
        check("t2_err", 128'(cnt_err), 0);

        // T3: count above capacity is clamped
        do_write(8'd0, DW'(250));
        clear_mon(); push_stream(PN - 1);
        start_read();
        wait_stream("t3_timeout");
        check("t3_valid_cnt", 128'(valid_cnt), PN - 1);
        check("t3_last_pid", 128'(last_pid), PN - 1);
        check("t3_done_cyc", 128'(done_rel), 5 + PN - 1);
        check("t3_err_set", 128'(cnt_err), 1);
        repeat (5) @(negedge clk);
        check("t3_err_sticky", 128'(cnt_err), 1);

        // T5: reset in the middle of a stream
        do_write(8'd0, DW'(6));
        check("t5_err_kept_over_write", 128'(cnt_err), 1);
        clear_mon(); push_stream(6);
        start_read();
        check("t5_err_cleared", 128'(cnt_err), 0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (rd_valid && rd_pid == 8'd2) found = 1'b1;
        end
        check("t5_reached_pid2", 128'(found), 1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 128'(rd_valid), 0);
        check("t5_rst_busy", 128'(rd_busy), 0);
        check("t5_rst_rden", 128'(ram_rden), 0);
        check("t5_rst_data", 128'(rd_data), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_no_valid_after_rst", 128'(valid_cnt), 1);
        check("t5_no_done_after_rst", 128'(done_cnt), 0);
        clear_mon(); push_stream(6);
        start_read();
        check("t5_restart_cnt_addr", 128'(ram_address), 0);
        check("t5_restart_rden", 128'(ram_rden), 1);
        wait_stream("t5_timeout");
        check("t5_valid_cnt", 128'(valid_cnt), 6);
        check("t5_first_valid", 128'(first_rel), 6);
        check("t5_done_cyc", 128'(done_rel), 11);

        // T4: read and write requested together, read wins
        do_write(8'd0, DW'(3));
        clear_mon(); push_stream(3);
        @(negedge clk);
        rd_start = 1'b1; wr_req = 1'b1; wr_addr = 8'd5; wr_data = aval;
        @(posedge clk);
        #1;
        base = cyc - 1;
        rd_start = 1'b0;
        check("t4_read_wins_rden", 128'(ram_rden), 1);
        check("t4_read_wins_wren", 128'(ram_wren), 0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (wr_ack) found = 1'b1;
        end
        wr_req = 1'b0;
        check("t4_ack_seen", 128'(found), 1);
        repeat (2) @(negedge clk);
        check("t4_valid_cnt", 128'(valid_cnt), 3);
        check("t4_done_cyc", 128'(done_rel), 8);
        check("t4_busy_low", 128'(busy_low_rel), 9);
        check("t4_ack_cyc", 128'(ack_rel), 10);
        do_write(8'd0, DW'(5));
        clear_mon(); push_stream(4);
        exp_q.push_back({8'd5, aval});
        start_read();
        wait_stream("t4_readback_timeout");
        check("t4_readback_cnt", 128'(valid_cnt), 5);
        check("t4_readback_pid", 128'(last_pid), 5);

`ifdef CELL_CTRL_WR_INTERLEAVE_EN
        // T6: one write slot inside the stream
        do_write(8'd0, DW'(4));
        clear_mon(); push_stream(4);
        start_read();
        repeat (3) @(negedge clk);
        wr_req = 1'b1; wr_addr = 8'd200; wr_data = aval;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (wr_ack) found = 1'b1;
        end
        wr_req = 1'b0;
        check("t6_ack_seen", 128'(found), 1);
        wait_stream("t6_timeout");
        check("t6_ack_cyc", 128'(ack_rel), 5);
        check("t6_valid_cnt", 128'(valid_cnt), 4);
        check("t6_done_cyc", 128'(done_rel), 10);
`endif

        check("never_rden_and_wren", 128'(both_hi), 0);
        check("ack_matches_wren", 128'(ack_mis), 0);
        check("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
